// File: rtl/constraint_eval_pkg.sv
// rtl/constraint_eval_pkg.sv - opcode, constraint-entry and FSM state types shared by the evaluator
package constraint_eval_pkg;

    // Entries are sized for the widest supported configuration; producers zero-extend.
    localparam int ENTRY_IDX_W = 8;
    localparam int ENTRY_K_W   = 64;

    typedef enum logic [2:0] {
        OP_NEQK  = 3'd0,
        OP_EQK   = 3'd1,
        OP_LAND  = 3'd2,
        OP_LOR   = 3'd3,
        OP_XORNZ = 3'd4,
        OP_ADDNZ = 3'd5,
        OP_SUBNZ = 3'd6,
        OP_ORNZ  = 3'd7
    } op_e;

    typedef struct packed {
        logic                   en;
        op_e                    op;
        logic [ENTRY_IDX_W-1:0] a;
        logic [ENTRY_IDX_W-1:0] b;
        logic [ENTRY_K_W-1:0]   k;
    } entry_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EVAL = 2'd1,
        S_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/constraint_op_eval.sv
// rtl/constraint_op_eval.sv - combinational evaluation of one constraint opcode, arithmetic modulo 2^VAR_W
module constraint_op_eval
    import constraint_eval_pkg::*;
#(
    parameter int VAR_W = 32
) (
    input  logic [VAR_W-1:0] a,
    input  logic [VAR_W-1:0] b,
    input  logic [VAR_W-1:0] k,
    input  op_e              op,
    output logic             hold
);

    logic [VAR_W-1:0] sum;
    logic [VAR_W-1:0] diff;

    always_comb begin
        sum  = a + b;
        diff = a - b - k;
        hold = 1'b0;
        case (op)
            OP_NEQK:  hold = (a != k);
            OP_EQK:   hold = (a == k);
            OP_LAND:  hold = (a != '0) && (b != '0);
            OP_LOR:   hold = (a != '0) || (b != '0);
            OP_XORNZ: hold = ((a ^ b) != '0);
            OP_ADDNZ: hold = (sum != '0);
            OP_SUBNZ: hold = (diff != '0);
            OP_ORNZ:  hold = ((a | b | k) != '0);
            default:  hold = 1'b0;
        endcase
    end

endmodule

// File: rtl/constraint_eval_seq.sv
// rtl/constraint_eval_seq.sv - sequential constraint checker, one table entry evaluated per cycle
module constraint_eval_seq
    import constraint_eval_pkg::*;
#(
    parameter int NUM_VARS = 25,
    parameter int VAR_W    = 32,
    parameter int NUM_CONS = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cfg_we,
    input  logic [$clog2(NUM_CONS)-1:0] cfg_addr,
    input  logic                        cfg_en,
    input  logic [2:0]                  cfg_op,
    input  logic [$clog2(NUM_VARS)-1:0] cfg_a,
    input  logic [$clog2(NUM_VARS)-1:0] cfg_b,
    input  logic [VAR_W-1:0]            cfg_k,
    output logic                        cfg_err,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [NUM_VARS*VAR_W-1:0]   in_vars,
    input  logic                        early_exit,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        out_sat,
    output logic [$clog2(NUM_CONS)-1:0] out_fail_idx,
    output logic [$clog2(NUM_CONS):0]   out_fail_cnt,
    output logic [31:0]                 stat_total,
    output logic [31:0]                 stat_sat
);

    localparam int CIDX_W = $clog2(NUM_CONS);

    state_e                    state_q, state_d;
    entry_t                    table_q [NUM_CONS];
    entry_t                    wr_entry, cur;
    logic [NUM_VARS*VAR_W-1:0] vars_q;
    logic                      early_q;
    logic [CIDX_W-1:0]         ptr_q;
    logic [CIDX_W-1:0]         fail_idx_q;
    logic [CIDX_W:0]           fail_cnt_q;
    logic                      cfg_err_q;
    logic                      accept, deliver, last_entry, cur_fail, hold;
    logic                      a_in_range, b_in_range;
    logic [VAR_W-1:0]          opnd_a, opnd_b, opnd_k;

    assign wr_entry = '{en: cfg_en, op: op_e'(cfg_op), a: ENTRY_IDX_W'(cfg_a),
                        b: ENTRY_IDX_W'(cfg_b), k: ENTRY_K_W'(cfg_k)};

    // Indices beyond the candidate width read as zero rather than aliasing other slots.
    assign cur        = table_q[ptr_q];
    assign a_in_range = int'(cur.a) < NUM_VARS;
    assign b_in_range = int'(cur.b) < NUM_VARS;
    assign opnd_a     = a_in_range ? vars_q[int'(cur.a)*VAR_W +: VAR_W] : '0;
    assign opnd_b     = b_in_range ? vars_q[int'(cur.b)*VAR_W +: VAR_W] : '0;
    assign opnd_k     = VAR_W'(cur.k);

    constraint_op_eval #(.VAR_W(VAR_W)) u_op_eval (
        .a    (opnd_a),
        .b    (opnd_b),
        .k    (opnd_k),
        .op   (cur.op),
        .hold (hold)
    );

    assign cur_fail   = (state_q == S_EVAL) && cur.en && !hold;
    assign last_entry = (ptr_q == CIDX_W'(NUM_CONS - 1));
    assign accept     = in_valid && in_ready;
    assign deliver    = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (in_valid) state_d = S_EVAL;
            S_EVAL:  if (last_entry || (early_q && cur_fail)) state_d = S_DONE;
            S_DONE:  if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready     = (state_q == S_IDLE);
        out_valid    = (state_q == S_DONE);
        out_sat      = (state_q == S_DONE) && (fail_cnt_q == '0);
        out_fail_idx = fail_idx_q;
        out_fail_cnt = fail_cnt_q;
        cfg_err      = cfg_err_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CONS; i++) table_q[i] <= '0;
            vars_q     <= '0;
            early_q    <= 1'b0;
            ptr_q      <= '0;
            fail_idx_q <= '0;
            fail_cnt_q <= '0;
            cfg_err_q  <= 1'b0;
            stat_total <= '0;
            stat_sat   <= '0;
        end else begin
            cfg_err_q <= cfg_we && (state_q != S_IDLE);
            if (cfg_we && (state_q == S_IDLE)) table_q[cfg_addr] <= wr_entry;

            if (accept) begin
                vars_q     <= in_vars;
                early_q    <= early_exit;
                ptr_q      <= '0;
                fail_idx_q <= '0;
                fail_cnt_q <= '0;
            end

            if (state_q == S_EVAL) begin
                ptr_q <= ptr_q + CIDX_W'(1);
                if (cur_fail) begin
                    if (fail_cnt_q == '0) fail_idx_q <= ptr_q;
                    fail_cnt_q <= fail_cnt_q + (CIDX_W+1)'(1);
                end
            end

            if (deliver) begin
                if (stat_total != '1) stat_total <= stat_total + 32'd1;
                if (out_sat && (stat_sat != '1)) stat_sat <= stat_sat + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_constraint_eval_seq.sv
// tb/tb_constraint_eval_seq.sv - vector-table and scoreboard bench for constraint_eval_seq
module tb_constraint_eval_seq;
    import constraint_eval_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_we;
    logic [1:0]  cfg_addr;
    logic        cfg_en;
    logic [2:0]  cfg_op;
    logic [1:0]  cfg_a, cfg_b;
    logic [7:0]  cfg_k;
    logic        cfg_err;
    logic        in_valid, in_ready;
    logic [31:0] in_vars;
    logic        early_exit;
    logic        out_valid, out_ready;
    logic        out_sat;
    logic [1:0]  out_fail_idx;
    logic [2:0]  out_fail_cnt;
    logic [31:0] stat_total, stat_sat;

    constraint_eval_seq #(.NUM_VARS(4), .VAR_W(8), .NUM_CONS(4)) dut (
        .clk(clk), .rst(rst),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_en(cfg_en), .cfg_op(cfg_op),
        .cfg_a(cfg_a), .cfg_b(cfg_b), .cfg_k(cfg_k), .cfg_err(cfg_err),
        .in_valid(in_valid), .in_ready(in_ready), .in_vars(in_vars), .early_exit(early_exit),
        .out_valid(out_valid), .out_ready(out_ready), .out_sat(out_sat),
        .out_fail_idx(out_fail_idx), .out_fail_cnt(out_fail_cnt),
        .stat_total(stat_total), .stat_sat(stat_sat)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       sat;
        logic [1:0] idx;
        logic [2:0] cnt;
        int         lat;
    } exp_t;

    typedef struct {
        logic [31:0] vars;
        logic        early;
        exp_t        exp;
    } vec_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   exp_total = 0;
    int   exp_sat = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic cfg_write(input logic [1:0] addr, input logic en, input op_e op,
                             input logic [1:0] a, input logic [1:0] b, input logic [7:0] k);
        @(negedge clk);
        cfg_we = 1'b1; cfg_addr = addr; cfg_en = en; cfg_op = op; cfg_a = a; cfg_b = b; cfg_k = k;
        @(negedge clk);
        cfg_we = 1'b0;
        check("cfg_err_idle_write", cfg_err, 1'b0);
    endtask

    // mode 0: plain run; 1: rejected write mid-evaluation; 2: write coincident with acceptance
    task automatic run_cand(input logic [31:0] v, input logic e, input int hold, input int mode);
        int   lat;
        logic done;
        exp_t x;
        @(negedge clk);
        in_vars = v; early_exit = e; in_valid = 1'b1; out_ready = (hold == 0);
        if (mode == 2) begin
            cfg_we = 1'b1; cfg_addr = 2'd1; cfg_en = 1'b1; cfg_op = OP_EQK; cfg_a = 2'd2; cfg_k = 8'h34;
        end
        check("in_ready_before_accept", in_ready, 1'b1);
        @(posedge clk);
        lat = 0;
        done = 1'b0;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
            in_valid = 1'b0;
            if (mode == 2 && lat == 1) cfg_we = 1'b0;
            if (mode == 1 && lat == 2) begin
                cfg_we = 1'b1; cfg_addr = 2'd1; cfg_en = 1'b1; cfg_op = OP_EQK; cfg_a = 2'd2; cfg_k = 8'h99;
            end
            if (mode == 1 && lat == 3) begin
                cfg_we = 1'b0;
                check("cfg_err_pulse", cfg_err, 1'b1);
            end
            if (mode == 1 && lat == 4) check("cfg_err_clear", cfg_err, 1'b0);
            if (out_valid) done = 1'b1;
        end
        if (!done) begin
            check("out_valid_timeout", 1'b0, 1'b1);
            out_ready = 1'b1;
            return;
        end
        if (sb.size() == 0) begin
            check("scoreboard_empty", 1'b1, 1'b0);
            return;
        end
        x = sb.pop_front();
        check("latency", lat, x.lat);
        check("out_sat", out_sat, x.sat);
        check("out_fail_idx", out_fail_idx, x.idx);
        check("out_fail_cnt", out_fail_cnt, x.cnt);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold_valid", out_valid, 1'b1);
            check("hold_sat", out_sat, x.sat);
            check("hold_idx", out_fail_idx, x.idx);
            check("hold_cnt", out_fail_cnt, x.cnt);
        end
        out_ready = 1'b1;
        @(posedge clk);
        exp_total++;
        if (x.sat) exp_sat++;
        @(negedge clk);
        check("valid_dropped", out_valid, 1'b0);
        check("ready_after", in_ready, 1'b1);
        check("stat_total", stat_total, exp_total);
        check("stat_sat", stat_sat, exp_sat);
    endtask

    function automatic exp_t mk(input logic s, input logic [1:0] i, input logic [2:0] c, input int l);
        exp_t r;
        r.sat = s; r.idx = i; r.cnt = c; r.lat = l;
        return r;
    endfunction

    vec_t vecs[6];

    initial begin
        int   seen;
        vecs[0] = '{vars: {8'h10, 8'h03, 8'h02, 8'h01}, early: 1'b0, exp: mk(1'b1, 2'd0, 3'd0, 5)};
        vecs[1] = '{vars: {8'h00, 8'h00, 8'h00, 8'h05}, early: 1'b0, exp: mk(1'b0, 2'd0, 3'd4, 5)};
        vecs[2] = '{vars: {8'h00, 8'h00, 8'h00, 8'h05}, early: 1'b1, exp: mk(1'b0, 2'd0, 3'd1, 2)};
        vecs[3] = '{vars: {8'h10, 8'h07, 8'h00, 8'h01}, early: 1'b0, exp: mk(1'b0, 2'd1, 3'd1, 5)};
        vecs[4] = '{vars: {8'h10, 8'h00, 8'h00, 8'h01}, early: 1'b1, exp: mk(1'b0, 2'd1, 3'd1, 3)};
        vecs[5] = '{vars: {8'h02, 8'hFE, 8'h02, 8'h01}, early: 1'b0, exp: mk(1'b0, 2'd2, 3'd2, 5)};

        rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_en = 1'b0; cfg_op = '0; cfg_a = '0; cfg_b = '0;
        cfg_k = '0; in_valid = 1'b0; in_vars = '0; early_exit = 1'b0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_sat", out_sat, 1'b0);
        check("rst_fail_idx", out_fail_idx, 2'd0);
        check("rst_fail_cnt", out_fail_cnt, 3'd0);
        check("rst_cfg_err", cfg_err, 1'b0);
        check("rst_stat_total", stat_total, 32'd0);
        check("rst_stat_sat", stat_sat, 32'd0);
        rst = 1'b0;

        cfg_write(2'd0, 1'b1, OP_NEQK,  2'd0, 2'd0, 8'h05);
        cfg_write(2'd1, 1'b1, OP_LAND,  2'd1, 2'd2, 8'h00);
        cfg_write(2'd2, 1'b1, OP_ADDNZ, 2'd2, 2'd3, 8'h00);
        cfg_write(2'd3, 1'b1, OP_EQK,   2'd3, 2'd0, 8'h10);

        foreach (vecs[i]) begin
            sb.push_back(vecs[i].exp);
            run_cand(vecs[i].vars, vecs[i].early, 0, 0);
        end

        // ADDNZ wrap-around with the rest of the table disabled
        cfg_write(2'd0, 1'b1, OP_ADDNZ, 2'd0, 2'd1, 8'h00);
        cfg_write(2'd1, 1'b0, OP_NEQK,  2'd0, 2'd0, 8'h00);
        cfg_write(2'd2, 1'b0, OP_NEQK,  2'd0, 2'd0, 8'h00);
        cfg_write(2'd3, 1'b0, OP_NEQK,  2'd0, 2'd0, 8'h00);
        sb.push_back(mk(1'b0, 2'd0, 3'd1, 5));
        run_cand({8'h00, 8'h00, 8'h01, 8'hFF}, 1'b0, 0, 0);
        sb.push_back(mk(1'b1, 2'd0, 3'd0, 5));
        run_cand({8'h00, 8'h00, 8'h01, 8'hFE}, 1'b0, 0, 0);

        // entry 1 written in the acceptance cycle must already apply
        sb.push_back(mk(1'b0, 2'd1, 3'd1, 5));
        run_cand({8'h00, 8'h33, 8'h01, 8'hFE}, 1'b0, 0, 2);

        // rejected write during EVAL, output held under back-pressure, then re-evaluated
        sb.push_back(mk(1'b0, 2'd0, 3'd1, 5));
        run_cand({8'h00, 8'h34, 8'h01, 8'hFF}, 1'b0, 3, 1);
        sb.push_back(mk(1'b0, 2'd0, 3'd1, 5));
        run_cand({8'h00, 8'h34, 8'h01, 8'hFF}, 1'b0, 0, 0);

        // reset in the middle of an evaluation abandons the candidate
        @(negedge clk);
        in_vars = {8'h00, 8'h00, 8'h01, 8'hFF}; early_exit = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_total = 0;
        exp_sat = 0;
        check("midrst_in_ready", in_ready, 1'b1);
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_stat_total", stat_total, 32'd0);
        check("midrst_stat_sat", stat_sat, 32'd0);
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("midrst_no_result", seen, 0);
        check("midrst_stat_total_later", stat_total, 32'd0);

        // table cleared by reset: every entry disabled, so anything satisfies
        sb.push_back(mk(1'b1, 2'd0, 3'd0, 5));
        run_cand({8'h00, 8'h00, 8'h00, 8'h05}, 1'b0, 0, 0);

        check("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
